element_link_arbiter: RTL and testbench

ELEMENT_LINK_ARBITER -- requirements
Module: element_link_arbiter

---
 rtl/element_pkg.sv | 18 +
 rtl/element_link_arbiter_rr_pick4.sv | 28 ++
 rtl/element_link_arbiter.sv | 156 +++++++++++++++
 tb/tb_element_link_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/element_pkg.sv
// Shared constants and types for the element link arbiter.
// Lock-state enum is used only when ELEMENT_LINK_ARB_LOCK_EN is defined.
package element_pkg;

    localparam int DATA_WIDTH_DEFAULT = 64;
    localparam int N_REQ              = 4;

    localparam logic [1:0] DOWN  = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] UP    = 2'd2;
    localparam logic [1:0] LEFT  = 2'd3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/element_link_arbiter_rr_pick4.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping from 3 to 0.
module rr_pick4 (
    input  logic [3:0] valid_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] idx_o,
    output logic       any_o
);

    logic [1:0] cand_s;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        idx_o  = ptr_i;
        any_o  = 1'b0;
        cand_s = ptr_i;
        for (int k = 3; k >= 0; k--) begin
            cand_s = ptr_i + 2'(k);
            if (valid_i[cand_s]) begin
                idx_o = cand_s;
                any_o = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/element_link_arbiter.sv
// Four-way round-robin link arbiter with a single-register output stage.
// Define ELEMENT_LINK_ARB_LOCK_EN to build in packet lock (owner holds until last).
module element_link_arbiter #(
    parameter int DATA_WIDTH = element_pkg::DATA_WIDTH_DEFAULT,
    parameter int N_REQ      = element_pkg::N_REQ
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            io_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] io_req_data,
    input  logic [N_REQ-1:0]            io_req_last,
    output logic [N_REQ-1:0]            io_req_ready,
    output logic                        io_out_valid,
    input  logic                        io_out_ready,
    output logic [DATA_WIDTH-1:0]       io_out_data,
    output logic [1:0]                  io_out_src,
    output logic [15:0]                 io_beat_count
);

    import element_pkg::*;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]            out_src_q,   out_src_d;
    logic [1:0]            ptr_q,       ptr_d;
    logic [15:0]           beat_q,      beat_d;

    logic [N_REQ-1:0]      elig_s;
    logic [1:0]            pick_idx_s;
    logic                  pick_any_s;
    logic                  load_en_s;
    logic                  accept_s;

`ifdef ELEMENT_LINK_ARB_LOCK_EN
    lock_state_e state_q, state_d;
    logic [1:0]  owner_q, owner_d;

    assign elig_s = (state_q == LOCKED) ? (io_req_valid & (N_REQ'(1) << owner_q)) : io_req_valid;

    // Lock FSM next state; ptr is frozen while a packet owns the link.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            UNLOCKED: begin
                if (accept_s) begin
                    ptr_d = pick_idx_s + 2'd1;
                    if (!io_req_last[pick_idx_s]) begin
                        state_d = LOCKED;
                        owner_d = pick_idx_s;
                    end else begin
                        state_d = UNLOCKED;
                    end
                end else begin
                    state_d = UNLOCKED;
                end
            end
            LOCKED: begin
                if (accept_s && io_req_last[pick_idx_s]) begin
                    state_d = UNLOCKED;
                    ptr_d   = owner_q + 2'd1;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = UNLOCKED;
                owner_d = 2'd0;
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNLOCKED;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^io_req_last;
    assign elig_s        = io_req_valid;

    // Pointer moves just past every accepted requester.
    always_comb begin
        if (accept_s) begin
            ptr_d = pick_idx_s + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end
`endif

    rr_pick4 u_pick (
        .valid_i (elig_s),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    assign load_en_s    = !out_valid_q || io_out_ready;
    assign accept_s     = load_en_s && pick_any_s;
    // Gated by reset so no handshake can be seen while the block is held in reset.
    assign io_req_ready = (accept_s && reset_n) ? (N_REQ'(1) << pick_idx_s) : {N_REQ{1'b0}};

    // Output register and beat counter next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load_en_s) begin
            out_valid_d = pick_any_s;
            if (pick_any_s) begin
                out_data_d = io_req_data[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                out_src_d  = pick_idx_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        if (out_valid_q && io_out_ready) begin
            beat_d = beat_q + 16'd1;
        end else begin
            beat_d = beat_q;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_src_q   <= 2'd0;
            ptr_q       <= 2'd0;
            beat_q      <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
        end
    end

    assign io_out_valid  = out_valid_q;
    assign io_out_data   = out_data_q;
    assign io_out_src    = out_src_q;
    assign io_beat_count = beat_q;

endmodule

// File: tb/tb_element_link_arbiter.sv
// Table-driven bench for element_link_arbiter plus reset, wrap and lock sequences.
module tb_element_link_arbiter;

    localparam int DW = 64;

    logic           clock;
    logic           reset_n;
    logic [3:0]     req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]     req_last;
    logic [3:0]     req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_src;
    logic [15:0]    beat_count;

    logic [DW-1:0]  dat [4];

    int pass_cnt;
    int total_cnt;

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  last;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_src;
        logic [15:0] exp_beat;
    } vec_t;

    vec_t tbl [17];

    element_link_arbiter #(.DATA_WIDTH(DW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .io_req_valid  (req_valid),
        .io_req_data   (req_data),
        .io_req_last   (req_last),
        .io_req_ready  (req_ready),
        .io_out_valid  (out_valid),
        .io_out_ready  (out_ready),
        .io_out_data   (out_data),
        .io_out_src    (out_src),
        .io_beat_count (beat_count)
    );

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one vector, check ready before the edge and outputs after it.
    task automatic apply(input vec_t v, input int n);
        req_valid = v.vld;
        req_last  = v.last;
        out_ready = v.ordy;
        #1;
        chk($sformatf("req_ready[%0d]", n), 64'(req_ready), 64'(v.exp_rdy));
        @(posedge clock);
        #1;
        chk($sformatf("out_valid[%0d]", n), 64'(out_valid), 64'(v.exp_ov));
        chk($sformatf("beat_count[%0d]", n), 64'(beat_count), 64'(v.exp_beat));
        if (v.exp_ov) begin
            chk($sformatf("out_src[%0d]", n), 64'(out_src), 64'(v.exp_src));
            chk($sformatf("out_data[%0d]", n), out_data, dat[v.exp_src]);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        dat[0] = 64'h1111_1111_1111_1111;
        dat[1] = 64'h2222_2222_2222_2222;
        dat[2] = 64'hA5A5_A5A5_A5A5_A5A5;
        dat[3] = 64'h4444_4444_4444_4444;

        //            vld    last   ordy  rdy    ov    src   beat
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'd1};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'd2};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'd3};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd4};
        tbl[5]  = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'd5};
        tbl[6]  = '{4'h4, 4'hF, 1'b0, 4'h4, 1'b1, 2'd2, 16'd5};
        tbl[7]  = '{4'h4, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 16'd5};
        tbl[8]  = '{4'h4, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 16'd5};
        tbl[9]  = '{4'h4, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 16'd5};
        tbl[10] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'd6};
        tbl[11] = '{4'hA, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'd6};
        tbl[12] = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 16'd6};
        tbl[13] = '{4'hA, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'd7};
        tbl[14] = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 16'd7};
        tbl[15] = '{4'hA, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'd8};
        tbl[16] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'd9};

        reset_n   = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_beat", 64'(beat_count), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], i);
        end

        // Reset while a word is held: clears immediately, ptr back to 0.
        apply('{4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 16'd9}, 100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_out_src", 64'(out_src), 64'd0);
        chk("midrst_beat", 64'(beat_count), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        apply('{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd0}, 101);

        // Beat counter wrap: 65535 handshakes then one more.
        repeat (65535) @(posedge clock);
        #1;
        chk("beat_ffff", 64'(beat_count), 64'h0000_0000_0000_FFFF);
        @(posedge clock);
        #1;
        chk("beat_wrap", 64'(beat_count), 64'd0);

`ifdef ELEMENT_LINK_ARB_LOCK_EN
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        apply('{4'h3, 4'hE, 1'b1, 4'h1, 1'b1, 2'd0, 16'd0}, 200);
        apply('{4'h3, 4'hE, 1'b1, 4'h1, 1'b1, 2'd0, 16'd1}, 201);
        apply('{4'h3, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd2}, 202);
        apply('{4'h3, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'd3}, 203);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
